uart_rx_frame_ctrl: RTL

Frame controller placed after the UART receiver. It consumes the receiver's byte strobe and byte, then hunts for a sync byte, a length byte, the payload and an XOR checksum. It buffers the payload and releases it only when the checksum matches, as a valid/ready byte stream with a last flag. It reports malformed, corrupt or stalled frames with an error pulse and an error code.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: synchronous write port, combinational read port.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_Clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data_c
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: sync/len/payload/XOR checksum, buffered release.
// Optional per-frame statistics counters are enabled with UART_FRAME_STATS_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 2000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Data_Valid,
  output logic [7:0]  o_Data_Byte,
  output logic        o_Data_Last,
  input  logic        i_Data_Ready,
  output logic        o_Frame_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Drop,
`ifdef UART_FRAME_STATS_EN
  output logic [15:0] o_Good_Count,
  output logic [15:0] o_Err_Count,
`endif
  output logic        o_Busy
);

  localparam int unsigned PW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  state_e        state_q, state_d;
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          valid_d, last_d, err_d, drop_d, busy_d;
  logic [7:0]    byte_d;
  logic [1:0]    code_d;

  logic          buf_we;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [7:0]    buf_rd_data;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_Clock   (i_Clock),
    .wr_en     (buf_we),
    .wr_addr   (buf_wr_addr),
    .wr_data   (i_Rx_Byte),
    .rd_addr   (buf_rd_addr),
    .rd_data_c (buf_rd_data)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    valid_d     = o_Data_Valid;
    byte_d      = o_Data_Byte;
    last_d      = o_Data_Last;
    err_d       = 1'b0;
    code_d      = o_Err_Code;
    drop_d      = 1'b0;
    buf_we      = 1'b0;
    buf_wr_addr = AW'(wr_ptr_q);
    buf_rd_addr = AW'(rd_ptr_q + PW'(1));

    unique case (state_q)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (i_Rx_DV) begin
          csum_d = i_Rx_Byte;
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_LEN))) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else begin
            len_d    = PW'(i_Rx_Byte);
            wr_ptr_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ i_Rx_Byte;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if ((wr_ptr_q + PW'(1)) == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        buf_rd_addr = '0;
        if (i_Rx_DV) begin
          if (i_Rx_Byte == csum_q) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
            valid_d  = 1'b1;
            byte_d   = buf_rd_data;
            last_d   = (len_q == PW'(1));
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_Rx_DV) drop_d = 1'b1;
        if (o_Data_Valid && i_Data_Ready) begin
          if (o_Data_Last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            byte_d  = '0;
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            byte_d   = buf_rd_data;
            last_d   = ((rd_ptr_q + PW'(2)) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte watchdog; a strobe on the terminal count takes precedence.
    if (((state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM)) && !i_Rx_DV) begin
      if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      o_Data_Valid <= 1'b0;
      o_Data_Byte  <= '0;
      o_Data_Last  <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= ERR_NONE;
      o_Drop       <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      o_Data_Valid <= valid_d;
      o_Data_Byte  <= byte_d;
      o_Data_Last  <= last_d;
      o_Frame_Err  <= err_d;
      o_Err_Code   <= code_d;
      o_Drop       <= drop_d;
      o_Busy       <= busy_d;
    end
  end

`ifdef UART_FRAME_STATS_EN
  // Saturating good-frame and error counters.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Good_Count <= '0;
      o_Err_Count  <= '0;
    end else begin
      if ((state_q == CSUM) && (state_d == DRAIN) && (o_Good_Count != 16'hFFFF))
        o_Good_Count <= o_Good_Count + 16'd1;
      if (err_d && (o_Err_Count != 16'hFFFF))
        o_Err_Count <= o_Err_Count + 16'd1;
    end
  end
`endif

endmodule
